// File: rtl/booth_pkg.sv
// Shared types and helpers for the Booth multiply-accumulate controller:
// FSM state encoding, operand/product widths and product sign extension.
package booth_pkg;

  localparam int OP_W   = 4;
  localparam int PROD_W = 8;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    ARM   = 3'd2,
    WAIT  = 3'd3,
    ACCUM = 3'd4,
    OUT   = 3'd5
  } state_e;

  // Callers narrow the 32-bit result to their own accumulator width.
  function automatic logic [31:0] sext_prod(input logic [PROD_W-1:0] p);
    return {{(32-PROD_W){p[PROD_W-1]}}, p};
  endfunction

endpackage

// File: rtl/booth_mac_acc.sv
// Signed accumulator with sticky overflow detection.
// Optional clamping on overflow is enabled with BOOTH_MAC_SAT_EN; otherwise the sum wraps.
module booth_mac_acc
  import booth_pkg::*;
#(
  parameter int ACC_W = 12
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr_i,
  input  logic              en_i,
  input  logic [PROD_W-1:0] product_i,
  output logic [ACC_W-1:0]  acc_o,
  output logic              ovf_o
);

  logic [ACC_W-1:0] acc_q, acc_d;
  logic             ovf_q, ovf_d;
  logic [ACC_W:0]   prod_ext;
  logic [ACC_W:0]   sum;
  logic             sum_ovf;

`ifdef BOOTH_MAC_SAT_EN
  localparam logic [ACC_W-1:0] SAT_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic [ACC_W-1:0] SAT_MIN = {1'b1, {(ACC_W-1){1'b0}}};
`endif

  // One guard bit: the top two bits disagree exactly when the sum leaves the signed ACC_W range.
  assign prod_ext = (ACC_W+1)'(sext_prod(product_i));
  assign sum      = {acc_q[ACC_W-1], acc_q} + prod_ext;
  assign sum_ovf  = sum[ACC_W] ^ sum[ACC_W-1];

  always_comb begin
    acc_d = acc_q;
    ovf_d = ovf_q;
    if (clr_i) begin
      acc_d = '0;
      ovf_d = 1'b0;
    end else if (en_i) begin
      ovf_d = ovf_q | sum_ovf;
`ifdef BOOTH_MAC_SAT_EN
      if (sum_ovf) begin
        acc_d = sum[ACC_W] ? SAT_MIN : SAT_MAX;
      end else begin
        acc_d = sum[ACC_W-1:0];
      end
`else
      acc_d = sum[ACC_W-1:0];
`endif
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      acc_q <= acc_d;
      ovf_q <= ovf_d;
    end
  end

  assign acc_o = acc_q;
  assign ovf_o = ovf_q;

endmodule

// File: rtl/booth_mac_ctrl.sv
// Sequencer around a 4-bit Booth multiplier: accepts operand pairs, runs the multiplier,
// accumulates products per group and hands the sum downstream. Saturation: BOOTH_MAC_SAT_EN.
module booth_mac_ctrl
  import booth_pkg::*;
#(
  parameter int ACC_W = 12,
  parameter int CNT_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [OP_W-1:0]   in_multiplier,
  input  logic [OP_W-1:0]   in_multiplicand,
  input  logic              in_last,
  output logic              mul_start,
  output logic [OP_W-1:0]   mul_multiplier,
  output logic [OP_W-1:0]   mul_multiplicand,
  input  logic              mul_busy,
  input  logic [PROD_W-1:0] mul_product,
  output logic              acc_valid,
  input  logic              acc_ready,
  output logic [ACC_W-1:0]  acc_out,
  output logic [CNT_W-1:0]  acc_count,
  output logic              acc_ovf
);

  state_e            state_q;
  logic              in_ready_q;
  logic              mul_start_q;
  logic              acc_valid_q;
  logic [OP_W-1:0]   mplier_q;
  logic [OP_W-1:0]   mcand_q;
  logic              last_q;
  logic [PROD_W-1:0] prod_q;
  logic [CNT_W-1:0]  count_q;
  logic              acc_en;
  logic              acc_clr;

  // in_ready_q stays low while reset is held and rises on the first edge after release.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      in_ready_q  <= 1'b0;
      mul_start_q <= 1'b0;
      acc_valid_q <= 1'b0;
      mplier_q    <= '0;
      mcand_q     <= '0;
      last_q      <= 1'b0;
      prod_q      <= '0;
      count_q     <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          in_ready_q <= 1'b1;
          if (in_valid && in_ready_q) begin
            mplier_q    <= in_multiplier;
            mcand_q     <= in_multiplicand;
            last_q      <= in_last;
            in_ready_q  <= 1'b0;
            mul_start_q <= 1'b1;
            state_q     <= START;
          end
        end
        START: begin
          mul_start_q <= 1'b0;
          state_q     <= ARM;
        end
        ARM: begin
          // The multiplier may not have raised busy yet, so it is not trusted this cycle.
          state_q <= WAIT;
        end
        WAIT: begin
          if (!mul_busy) begin
            prod_q  <= mul_product;
            state_q <= ACCUM;
          end
        end
        ACCUM: begin
          count_q <= count_q + CNT_W'(1);
          if (last_q) begin
            acc_valid_q <= 1'b1;
            state_q     <= OUT;
          end else begin
            in_ready_q <= 1'b1;
            state_q    <= IDLE;
          end
        end
        OUT: begin
          if (acc_ready) begin
            acc_valid_q <= 1'b0;
            count_q     <= '0;
            in_ready_q  <= 1'b1;
            state_q     <= IDLE;
          end
        end
        default: begin
          in_ready_q  <= 1'b0;
          mul_start_q <= 1'b0;
          acc_valid_q <= 1'b0;
          state_q     <= IDLE;
        end
      endcase
    end
  end

  assign acc_en  = (state_q == ACCUM);
  assign acc_clr = (state_q == OUT) && acc_ready;

  booth_mac_acc #(
    .ACC_W(ACC_W)
  ) u_acc (
    .clk      (clk),
    .rst      (rst),
    .clr_i    (acc_clr),
    .en_i     (acc_en),
    .product_i(prod_q),
    .acc_o    (acc_out),
    .ovf_o    (acc_ovf)
  );

  assign in_ready         = in_ready_q;
  assign mul_start        = mul_start_q;
  assign mul_multiplier   = mplier_q;
  assign mul_multiplicand = mcand_q;
  assign acc_valid        = acc_valid_q;
  assign acc_count        = count_q;

endmodule
